// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use/branch/memory-wait stall and flush control; PIPE_HAZARD_PERF_EN adds stall/bubble counters
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int WCNT_W = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       IDEX_MemRead_i,
  input  logic [4:0] IDEX_RD_i,
  input  logic [4:0] IFID_rs1_i,
  input  logic [4:0] IFID_rs2_i,
  input  logic       branch_taken_i,
  input  logic       EXMEM_MemRead_i,
  input  logic       EXMEM_MemWrite_i,
  input  logic       mem_ack_i,
  output logic       mem_req_o,
  output logic       MemStall_o,
  output logic       PC_write_o,
  output logic       IFID_write_o,
  output logic       IFID_flush_o,
  output logic       IDEX_bubble_o,
`ifdef PIPE_HAZARD_PERF_EN
  output logic       err_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] bubble_cnt_o
`else
  output logic       err_o
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;
  state_t state, state_n;
  logic [WCNT_W-1:0] wcnt, wcnt_n;
  logic mem_op, luh, stall;
  always_comb begin
    mem_op = EXMEM_MemRead_i | EXMEM_MemWrite_i;
    luh = rst_i & IDEX_MemRead_i & (IDEX_RD_i != 5'd0) &
          ((IDEX_RD_i == IFID_rs1_i) | (IDEX_RD_i == IFID_rs2_i));
    state_n = state;
    wcnt_n = wcnt;
    mem_req_o = 1'b0;
    stall = 1'b0;
    unique case (state)
      IDLE: begin
        mem_req_o = mem_op;
        stall = mem_op & ~mem_ack_i;
        state_n = stall ? WAIT : IDLE;
        wcnt_n = '0;
      end
      WAIT: begin
        mem_req_o = 1'b1;
        stall = ~mem_ack_i;
        wcnt_n = mem_ack_i ? '0 : wcnt + 1'b1;
        state_n = mem_ack_i ? IDLE : (wcnt == WCNT_W'(MAX_WAIT - 1)) ? ERR : WAIT;
      end
      ERR: stall = 1'b1;
      default: state_n = IDLE;
    endcase
    mem_req_o = mem_req_o & rst_i;
    MemStall_o = stall & rst_i;
    PC_write_o = ~MemStall_o & ~luh;
    IFID_write_o = PC_write_o;
    IFID_flush_o = PC_write_o & branch_taken_i & rst_i;
    IDEX_bubble_o = ~MemStall_o & luh;
    err_o = rst_i & (state == ERR);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      wcnt <= '0;
    end else begin
      state <= state_n;
      wcnt <= wcnt_n;
    end
  end
`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      bubble_cnt_o <= '0;
    end else begin
      stall_cnt_o <= stall_cnt_o + 32'(MemStall_o);
      bubble_cnt_o <= bubble_cnt_o + 32'(IDEX_bubble_o);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
  localparam int MAXW = 4;
  logic clk = 1'b0;
  logic rst, idmr, br, mr, mw, ack;
  logic [4:0] rd, rs1, rs2;
  logic req, stl, pcw, ifw, fl, bub, err;
  logic [7:0] lit = 8'd0;
  int checks = 0, errors = 0;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] sc, bc;
`endif
  pipe_hazard_ctrl #(.MAX_WAIT(MAXW), .WCNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(idmr), .IDEX_RD_i(rd),
    .IFID_rs1_i(rs1), .IFID_rs2_i(rs2), .branch_taken_i(br),
    .EXMEM_MemRead_i(mr), .EXMEM_MemWrite_i(mw), .mem_ack_i(ack),
    .mem_req_o(req), .MemStall_o(stl), .PC_write_o(pcw), .IFID_write_o(ifw),
    .IFID_flush_o(fl), .IDEX_bubble_o(bub),
`ifdef PIPE_HAZARD_PERF_EN
    .err_o(err), .stall_cnt_o(sc), .bubble_cnt_o(bc)
`else
    .err_o(err)
`endif
  );
  always #5 clk = ~clk;
  // access model: busy = request outstanding past its first cycle, waited = stalled WAIT cycles so far
  initial begin
    logic busy, dead, e_req, e_stl, e_luh, e_err, mop;
    logic [6:0] exp, act;
    int waited;
    longint m_sc, m_bc;
    busy = 0; dead = 0; waited = 0; m_sc = 0; m_bc = 0;
    forever begin
      @(negedge clk);
      act = {req, stl, pcw, ifw, fl, bub, err};
      mop = mr | mw;
      e_luh = idmr && rd != 0 && (rd == rs1 || rd == rs2);
      if (!rst) begin
        exp = 7'b0011000;
        busy = 0; dead = 0; waited = 0;
      end else begin
        e_err = dead;
        if (dead) begin
          e_req = 0; e_stl = 1;
        end else if (busy) begin
          e_req = 1; e_stl = !ack;
          if (ack) busy = 0;
          else if (waited == MAXW - 1) begin dead = 1; busy = 0; end
          else waited++;
        end else begin
          e_req = mop; e_stl = mop && !ack;
          if (e_stl) begin busy = 1; waited = 0; end
        end
        exp = {e_req, e_stl, !e_stl && !e_luh, !e_stl && !e_luh,
               !e_stl && !e_luh && br, !e_stl && e_luh, e_err};
      end
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model t=%0t got=%b want=%b", $time, act, exp);
      end
      if (lit[7]) begin
        checks++;
        if (act !== lit[6:0]) begin
          errors++;
          $display("FAIL literal t=%0t got=%b want=%b", $time, act, lit[6:0]);
        end
        checks++;
        if (exp !== lit[6:0]) begin
          errors++;
          $display("FAIL model_pin t=%0t model=%b want=%b", $time, exp, lit[6:0]);
        end
      end
`ifdef PIPE_HAZARD_PERF_EN
      checks++;
      if (sc !== 32'(m_sc) || bc !== 32'(m_bc)) begin
        errors++;
        $display("FAIL perf t=%0t got=%0d/%0d want=%0d/%0d", $time, sc, bc, m_sc, m_bc);
      end
      if (!rst) begin m_sc = 0; m_bc = 0; end
      else begin m_sc += longint'(exp[5]); m_bc += longint'(exp[1]); end
`endif
    end
  end
  task automatic cyc(input logic r, input logic im, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic b, input logic m_r, input logic m_w,
                     input logic a, input logic [7:0] l);
    rst = r; idmr = im; rd = d; rs1 = s1; rs2 = s2; br = b; mr = m_r; mw = m_w; ack = a; lit = l;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 0; idmr = 0; rd = 0; rs1 = 0; rs2 = 0; br = 0; mr = 0; mw = 0; ack = 0;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, 8'b1_0011000);
    cyc(0, 1, 5, 0, 5, 1, 0, 0, 0, 8'b1_0011000);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1_0011000);
    cyc(1, 1, 5, 0, 5, 0, 0, 0, 0, 8'b1_0000010);
    cyc(1, 0, 5, 0, 5, 0, 0, 0, 0, 8'b1_0011000);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 8'b1_0011000);
    cyc(1, 1, 7, 7, 1, 1, 0, 0, 0, 8'b1_0000010);
    cyc(1, 0, 7, 7, 1, 1, 0, 0, 0, 8'b1_0011100);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 8'b1_1100000);
    cyc(1, 1, 3, 3, 0, 1, 1, 0, 0, 8'b1_1100000);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 8'b1_1100000);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 1, 8'b1_1011000);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 1, 8'b1_1011000);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 8'b1_1100000);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 8'b1_1011000);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 8'b1_0011000);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 8'b1_1100000);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 8'b1_1100000);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 1, 8'b1_1011000);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1_0011000);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 8'b1_1100000);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 8'b1_1100000);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'b1_0011000);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 8'b1_0011000);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 8'b1_1100000);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 8'b1_1100000);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 1, 8'b1_0100001);
    cyc(1, 1, 2, 2, 0, 1, 0, 0, 1, 8'b1_0100001);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1_0011000);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1_0011000);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 19) != 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 8'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
